leaf_stream_packetizer: RTL and testbench

Transmit-side leaf interface that sits inside a page, between the page's user logic and the butterfly-fat-tree (BFT) leaf port. It accepts a 32-bit valid/ready stream, buffers it, and emits 49-bit BFT packets on `dout_leaf_interface2bft` under credit-based flow control. It consumes credit-return packets arriving on `din_leaf_bft2interface` and supports single-packet retransmission on `resend`.

---
 rtl/leaf_pkt_pkg.sv | 48 ++++
 rtl/leaf_stream_packetizer_if.sv | 14 +
 rtl/leaf_sync_fifo.sv | 82 ++++++++
 rtl/leaf_stream_packetizer.sv | 153 +++++++++++++++
 tb/tb_leaf_stream_packetizer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg: shared BFT packet layout for the leaf interface blocks.
// Provides field widths and bit positions, type encodings, the packetizer
// FSM state type and a helper that assembles a 49-bit packet from fields.
package leaf_pkt_pkg;

    localparam int unsigned PKT_W    = 49;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LEAF_W   = 5;
    localparam int unsigned PORT_W   = 4;
    localparam int unsigned SEQ_W    = 6;
    localparam int unsigned CREDIT_W = 4;

    localparam int unsigned PAY_LSB   = 0;
    localparam int unsigned SEQ_LSB   = 32;
    localparam int unsigned TYPE_BIT  = 38;
    localparam int unsigned PORT_LSB  = 39;
    localparam int unsigned LEAF_LSB  = 43;
    localparam int unsigned VALID_BIT = 48;

    localparam logic TYPE_DATA   = 1'b0;
    localparam logic TYPE_CREDIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPLAY = 2'd2
    } pkt_state_e;

    // Build a valid packet; unused bit positions are zero.
    function automatic logic [PKT_W-1:0] pack_pkt(
        input logic [LEAF_W-1:0] leaf,
        input logic [PORT_W-1:0] port,
        input logic              ptype,
        input logic [SEQ_W-1:0]  seq,
        input logic [DATA_W-1:0] payload
    );
        logic [PKT_W-1:0] p;
        p                        = '0;
        p[VALID_BIT]             = 1'b1;
        p[LEAF_LSB +: LEAF_W]    = leaf;
        p[PORT_LSB +: PORT_W]    = port;
        p[TYPE_BIT]              = ptype;
        p[SEQ_LSB +: SEQ_W]      = seq;
        p[PAY_LSB +: DATA_W]     = payload;
        return p;
    endfunction

endpackage

// File: rtl/leaf_stream_packetizer_if.sv
// leaf_stream_packetizer_if: 32-bit valid/ready payload stream.
//   s_data  : payload word
//   s_valid : payload valid (master -> slave)
//   s_ready : word accepted when s_valid & s_ready (slave -> master)
interface leaf_stream_packetizer_if;

    logic [leaf_pkt_pkg::DATA_W-1:0] s_data;
    logic                            s_valid;
    logic                            s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/leaf_sync_fifo.sv
// leaf_sync_fifo: synchronous FIFO with a registered head word.
//   clk, reset     : clock, synchronous active-high reset
//   i_push, i_data : write request (ignored when full)
//   i_pop          : consume head word (ignored when empty)
//   o_data         : registered head word, valid when !o_empty
//   o_full         : DEPTH words held (array plus head register)
//   o_empty        : no head word available to read
//   o_drained      : no words held anywhere
module leaf_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drained
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_mcount;
    logic [WIDTH-1:0] r_head;
    logic             r_head_valid;

    logic w_push;
    logic w_pop;
    logic w_load;

    // Occupancy counts the head register so capacity is exactly DEPTH.
    assign o_full    = (r_mcount + CW'(r_head_valid)) == CW'(DEPTH);
    assign o_empty   = !r_head_valid;
    assign o_drained = !r_head_valid && (r_mcount == '0);
    assign o_data    = r_head;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && r_head_valid;
    assign w_load = (r_mcount != '0) && (!r_head_valid || w_pop);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers, array count and head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_mcount     <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_load) begin
                r_rptr       <= r_rptr + AW'(1);
                r_head       <= r_mem[r_rptr];
                r_head_valid <= 1'b1;
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end
            if (w_push && !w_load) begin
                r_mcount <= r_mcount + CW'(1);
            end else if (!w_push && w_load) begin
                r_mcount <= r_mcount - CW'(1);
            end
        end
    end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer: buffers a 32-bit stream and emits BFT data
// packets under credit flow control, with single-packet replay.
//   clk, reset              : clock, synchronous active-high reset
//   ap_start                : leave IDLE, latching dest_leaf/dest_port
//   dest_leaf, dest_port    : destination of emitted packets
//   s_axis                  : payload stream (slave side)
//   din_leaf_bft2interface  : incoming packets; credit packets add credits
//   dout_leaf_interface2bft : registered outgoing packet, zero when idle
//   resend                  : retransmit last data packet
//   busy                    : words buffered or replay pending
//   credit_err              : sticky credit overflow flag
module leaf_stream_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CREDITS    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ap_start,
    input  logic [LEAF_W-1:0]        dest_leaf,
    input  logic [PORT_W-1:0]        dest_port,
    leaf_stream_packetizer_if.slave  s_axis,
    input  logic [PKT_W-1:0]         din_leaf_bft2interface,
    output logic [PKT_W-1:0]         dout_leaf_interface2bft,
    input  logic                     resend,
    output logic                     busy,
    output logic                     credit_err
);

    localparam int unsigned CRW  = 4;
    localparam int unsigned SUMW = CRW + 1;

    pkt_state_e        r_state;
    logic [LEAF_W-1:0] r_leaf;
    logic [PORT_W-1:0] r_port;
    logic [CRW-1:0]    r_credits;
    logic [SEQ_W-1:0]  r_seq;
    logic [PKT_W-1:0]  r_replay;
    logic              r_sent;
    logic              r_pending;
    logic [PKT_W-1:0]  r_dout;
    logic              r_credit_err;

    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_drained;
    logic              w_push;
    logic              w_emit;
    logic              w_replay;
    logic              w_credit_in;
    logic [SUMW-1:0]   w_credit_sum;
    logic [PKT_W-1:0]  w_pkt;
    logic              w_unused_din;

    assign s_axis.s_ready          = (r_state != ST_IDLE) && !w_full;
    assign w_push                  = s_axis.s_valid && s_axis.s_ready;
    assign busy                    = !w_drained || r_pending;
    assign credit_err              = r_credit_err;
    assign dout_leaf_interface2bft = r_dout;

    // Fresh data may go out in RUN or in the cycle REPLAY hands back to RUN.
    assign w_emit   = (r_state != ST_IDLE) && !w_empty && (r_credits != '0) && !r_pending;
    assign w_replay = (r_state == ST_RUN) && r_pending && r_sent;
    assign w_pkt    = pack_pkt(r_leaf, r_port, TYPE_DATA, r_seq, w_head);

    assign w_credit_in  = din_leaf_bft2interface[VALID_BIT] &&
                          (din_leaf_bft2interface[TYPE_BIT] == TYPE_CREDIT);
    assign w_credit_sum = SUMW'(r_credits)
                        + (w_credit_in ? SUMW'(din_leaf_bft2interface[CREDIT_W-1:0]) : SUMW'(0))
                        - SUMW'(w_emit);

    assign w_unused_din = ^{din_leaf_bft2interface[PKT_W-2:TYPE_BIT+1],
                            din_leaf_bft2interface[TYPE_BIT-1:CREDIT_W]};

    leaf_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    (s_axis.s_data),
        .i_pop     (w_emit),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_drained (w_drained)
    );

    // Control FSM with credit, sequence and replay bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_leaf       <= '0;
            r_port       <= '0;
            r_credits    <= CRW'(CREDITS);
            r_seq        <= '0;
            r_replay     <= '0;
            r_sent       <= 1'b0;
            r_pending    <= 1'b0;
            r_dout       <= '0;
            r_credit_err <= 1'b0;
        end else begin
            r_dout <= '0;

            if (w_credit_sum > SUMW'(CREDITS)) begin
                r_credits    <= CRW'(CREDITS);
                r_credit_err <= 1'b1;
            end else begin
                r_credits <= w_credit_sum[CRW-1:0];
            end

            // A new request wins over clearing, so resend during REPLAY re-arms.
            if (resend) begin
                r_pending <= 1'b1;
            end else if (w_replay || (r_pending && !r_sent)) begin
                r_pending <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_leaf  <= dest_leaf;
                        r_port  <= dest_port;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_replay) begin
                        r_dout  <= r_replay;
                        r_state <= ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_emit) begin
                r_dout   <= w_pkt;
                r_replay <= w_pkt;
                r_seq    <= r_seq + SEQ_W'(1);
                r_sent   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// tb_leaf_stream_packetizer: directed self-checking bench for the packetizer.
module tb_leaf_stream_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic [4:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [48:0] din;
    logic [48:0] dout;
    logic        resend;
    logic        busy;
    logic        credit_err;

    leaf_stream_packetizer_if sif ();

    leaf_stream_packetizer #(
        .FIFO_DEPTH (16),
        .CREDITS    (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .s_axis                  (sif),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .busy                    (busy),
        .credit_err              (credit_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [48:0] q [$];
    int          qt [$];
    logic [4:0]  cur_leaf;
    logic [3:0]  cur_port;

    // Packet monitor on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dout[48]) begin
            q.push_back(dout);
            qt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [48:0] mk(input int s, input logic [31:0] d);
        logic [5:0] s6;
        s6 = 6'(s);
        return {1'b1, cur_leaf, cur_port, 1'b0, s6, d};
    endfunction

    function automatic logic [48:0] mk_credit(input logic [3:0] n);
        return {1'b1, 5'd0, 4'd0, 1'b1, 6'd0, 28'd0, n};
    endfunction

    function automatic logic [48:0] pkt_at(input int i);
        if (i < q.size()) return q[i];
        return '0;
    endfunction

    function automatic int t_at(input int i);
        if (i < qt.size()) return qt[i];
        return -1000;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ap_start = 1'b0; resend = 1'b0; din = '0;
        sif.s_valid = 1'b0; sif.s_data = '0;
        step(2);
        reset = 1'b0;
        q.delete(); qt.delete();
    endtask

    task automatic start(input logic [4:0] l, input logic [3:0] p);
        cur_leaf = l; cur_port = p;
        dest_leaf = l; dest_port = p; ap_start = 1'b1;
        step(1);
        ap_start = 1'b0;
    endtask

    task automatic push_n(input logic [31:0] base, input int n);
        sif.s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            sif.s_data = base + 32'(i);
            step(1);
        end
        sif.s_valid = 1'b0;
    endtask

    task automatic credit(input logic [3:0] n);
        din = mk_credit(n);
        step(1);
        din = '0;
    endtask

    initial begin
        dest_leaf = '0; dest_port = '0; cur_leaf = '0; cur_port = '0;
        reset = 1'b1; ap_start = 1'b0; resend = 1'b0; din = '0;
        sif.s_valid = 1'b0; sif.s_data = '0;
        step(2);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ready", 64'(sif.s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cerr", 64'(credit_err), 64'd0);

        // Basic latency and destination sampling
        do_reset();
        check("idle_ready", 64'(sif.s_ready), 64'd0);
        start(5'd3, 4'd2);
        dest_leaf = 5'd31; dest_port = 4'd15;
        check("run_ready", 64'(sif.s_ready), 64'd1);
        sif.s_valid = 1'b1; sif.s_data = 32'hDEADBEEF;
        step(1);
        sif.s_valid = 1'b0;
        check("lat_t0", 64'(dout), 64'd0);
        step(1);
        check("lat_t1", 64'(dout), 64'd0);
        step(1);
        check("basic_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 1'b0, 6'd0, 32'hDEADBEEF}));
        step(1);
        check("basic_idle", 64'(dout), 64'd0);
        check("basic_busy", 64'(busy), 64'd0);

        // Credit exhaustion, data-type din ignored, credit return
        do_reset();
        start(5'd3, 4'd2);
        push_n(32'h1000_0000, 12);
        step(20);
        check("exh_count", 64'(q.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("exh_pkt", 64'(pkt_at(i)), 64'(mk(i, 32'h1000_0000 + 32'(i))));
        check("exh_dout", 64'(dout), 64'd0);
        check("exh_busy", 64'(busy), 64'd1);
        din = {1'b1, 5'd0, 4'd0, 1'b0, 6'd0, 28'd0, 4'd4};
        step(1);
        din = '0;
        step(5);
        check("data_din_ignored", 64'(q.size()), 64'd8);
        credit(4'd4);
        step(10);
        check("ret_count", 64'(q.size()), 64'd12);
        for (int i = 8; i < 12; i++) check("ret_pkt", 64'(pkt_at(i)), 64'(mk(i, 32'h1000_0000 + 32'(i))));
        check("ret_busy", 64'(busy), 64'd0);

        // Credit intake in the same cycle as an emission
        do_reset();
        start(5'd3, 4'd2);
        push_n(32'hB000_0000, 7);
        step(12);
        check("sim_pre", 64'(q.size()), 64'd7);
        sif.s_valid = 1'b1; sif.s_data = 32'hC000_0000; step(1);
        sif.s_data = 32'hC000_0001; step(1);
        sif.s_data = 32'hC000_0002; din = mk_credit(4'd2); step(1);
        sif.s_valid = 1'b0; din = '0;
        step(10);
        check("sim_count", 64'(q.size()), 64'd10);
        for (int i = 7; i < 10; i++) check("sim_pkt", 64'(pkt_at(i)), 64'(mk(i, 32'hC000_0000 + 32'(i - 7))));
        check("sim_b2b_a", 64'(t_at(8) - t_at(7)), 64'd1);
        check("sim_b2b_b", 64'(t_at(9) - t_at(8)), 64'd1);
        push_n(32'hC000_0003, 1);
        step(10);
        check("sim_no_extra", 64'(q.size()), 64'd10);

        // Replay of last packet
        do_reset();
        start(5'd3, 4'd2);
        push_n(32'hA000_0000, 3);
        step(6);
        check("rep_pre", 64'(q.size()), 64'd3);
        resend = 1'b1;
        step(1);
        resend = 1'b0;
        check("rep_wait", 64'(dout), 64'd0);
        step(1);
        check("rep_pkt", 64'(dout), 64'(mk(2, 32'hA000_0002)));
        step(1);
        check("rep_after", 64'(dout), 64'd0);
        push_n(32'hA000_0003, 1);
        step(4);
        check("rep_fresh", 64'(pkt_at(4)), 64'(mk(3, 32'hA000_0003)));
        push_n(32'hA000_0004, 6);
        step(12);
        check("rep_credit_count", 64'(q.size()), 64'd9);
        check("rep_credit_last", 64'(pkt_at(8)), 64'(mk(7, 32'hA000_0007)));

        // Resend before any packet is ignored
        do_reset();
        start(5'd3, 4'd2);
        resend = 1'b1;
        step(1);
        resend = 1'b0;
        step(5);
        check("early_no_pkt", 64'(q.size()), 64'd0);
        check("early_busy", 64'(busy), 64'd0);
        push_n(32'h5EED_0000, 1);
        step(4);
        check("early_first", 64'(pkt_at(0)), 64'(mk(0, 32'h5EED_0000)));
        check("early_count", 64'(q.size()), 64'd1);

        // FIFO full backpressure, no loss
        do_reset();
        start(5'd3, 4'd2);
        push_n(32'hF000_0000, 8);
        step(12);
        push_n(32'hF100_0000, 16);
        check("full_ready", 64'(sif.s_ready), 64'd0);
        sif.s_valid = 1'b1; sif.s_data = 32'h0000_0BAD;
        step(3);
        sif.s_valid = 1'b0;
        check("full_busy", 64'(busy), 64'd1);
        credit(4'd8);
        check("full_ready_low", 64'(sif.s_ready), 64'd0);
        step(1);
        check("full_ready_back", 64'(sif.s_ready), 64'd1);
        step(12);
        credit(4'd8);
        step(12);
        check("full_count", 64'(q.size()), 64'd24);
        for (int i = 0; i < 16; i++) check("full_pkt", 64'(pkt_at(8 + i)), 64'(mk(8 + i, 32'hF100_0000 + 32'(i))));
        check("full_cerr", 64'(credit_err), 64'd0);

        // Sequence wrap over 70 packets
        do_reset();
        start(5'd17, 4'd9);
        for (int b = 0; b < 10; b++) begin
            push_n(32'h7000_0000 + 32'(7 * b), 7);
            step(10);
            credit(4'd7);
        end
        step(5);
        check("wrap_count", 64'(q.size()), 64'd70);
        check("wrap_63", 64'(pkt_at(63)), 64'(mk(63, 32'h7000_003F)));
        check("wrap_0", 64'(pkt_at(64)), 64'(mk(0, 32'h7000_0040)));
        check("wrap_5", 64'(pkt_at(69)), 64'(mk(5, 32'h7000_0045)));
        check("wrap_cerr", 64'(credit_err), 64'd0);

        // Credit overflow saturates and is sticky
        do_reset();
        start(5'd3, 4'd2);
        check("sat_cerr0", 64'(credit_err), 64'd0);
        credit(4'd15);
        check("sat_cerr1", 64'(credit_err), 64'd1);
        push_n(32'h5A00_0000, 10);
        step(15);
        check("sat_count", 64'(q.size()), 64'd8);
        check("sat_sticky", 64'(credit_err), 64'd1);

        // Reset mid-stream with buffered words
        do_reset();
        start(5'd3, 4'd2);
        push_n(32'h8000_0000, 8);
        step(12);
        push_n(32'h8100_0000, 5);
        step(3);
        check("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        step(1);
        check("mid_dout", 64'(dout), 64'd0);
        check("mid_ready", 64'(sif.s_ready), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        q.delete(); qt.delete();
        step(10);
        check("mid_no_pkt", 64'(q.size()), 64'd0);
        start(5'd3, 4'd2);
        step(10);
        check("mid_discarded", 64'(q.size()), 64'd0);
        push_n(32'h8200_0000, 1);
        step(4);
        check("mid_restart", 64'(pkt_at(0)), 64'(mk(0, 32'h8200_0000)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
